// File: rtl/ps2_host_tx_if.sv
// Command handshake between the top-level controller and the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic [1:0] tx_err_code;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_busy, tx_done, tx_err, tx_err_code
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_busy, tx_done, tx_err, tx_err_code
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-clock frame, ACK check.
// Optional device-clock watchdog enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_clk_i,
    input  logic         ps2_data_i,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe,
    ps2_host_tx_if.slave tx
);
    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

    if (INHIBIT_CYCLES == 0 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("ps2_host_tx: INHIBIT_CYCLES must be >= 1 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_WAIT_IDLE
    } state_e;

    state_e             state_q, state_d;
    logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
    logic [3:0]         n_q, n_d;
    logic [9:0]         sh_q, sh_d;
    logic               clk_oe_q, clk_oe_d;
    logic               data_oe_q, data_oe_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d, clk_prev_q, clk_prev_d;
    logic               data_meta_q, data_meta_d, data_sync_q, data_sync_d;
    logic               fall;

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
    logic [WD_W-1:0]    wd_q, wd_d;
`endif

    // Two-stage synchronisers plus clock history for falling-edge detection
    always_comb begin
        clk_meta_d  = ps2_clk_i;
        clk_sync_d  = clk_meta_q;
        clk_prev_d  = clk_sync_q;
        data_meta_d = ps2_data_i;
        data_sync_d = data_meta_q;
    end

    assign fall = clk_prev_q & ~clk_sync_q;

    always_comb begin
        state_d    = state_q;
        inh_cnt_d  = inh_cnt_q;
        n_d        = n_q;
        sh_d       = sh_q;
        clk_oe_d   = 1'b0;
        data_oe_d  = data_oe_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
`ifdef PS2_HOST_TX_TIMEOUT_EN
        wd_d       = wd_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (tx.tx_valid) begin
                    state_d   = S_INHIBIT;
                    inh_cnt_d = '0;
                    n_d       = 4'd0;
                    sh_d      = {1'b1, ~^tx.tx_data, tx.tx_data};
                    clk_oe_d  = 1'b1;
                end
            end
            S_INHIBIT: begin
                clk_oe_d = 1'b1;
                if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    state_d   = S_REQ;
                    data_oe_d = 1'b1;
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end
            S_REQ: begin
                // Start bit stays driven low while the clock is handed to the device
                state_d   = S_SHIFT;
                data_oe_d = 1'b1;
`ifdef PS2_HOST_TX_TIMEOUT_EN
                wd_d      = '0;
`endif
            end
            S_SHIFT: begin
                if (fall) begin
                    n_d = n_q + 4'd1;
                    if (n_q == 4'd10) begin
                        if (data_sync_q) begin
                            state_d    = S_IDLE;
                            err_d      = 1'b1;
                            err_code_d = 2'b01;
                        end else begin
                            state_d = S_WAIT_IDLE;
                        end
                    end else begin
                        data_oe_d = ~sh_q[0];
                        sh_d      = {1'b0, sh_q[9:1]};
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (clk_sync_q && data_sync_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
        // Watchdog on the gap between device clock falls
        if (state_q == S_SHIFT || state_q == S_WAIT_IDLE) begin
            if (fall) begin
                wd_d = '0;
            end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                state_d    = S_IDLE;
                done_d     = 1'b0;
                err_d      = 1'b1;
                err_code_d = 2'b10;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
`endif

        if (state_d == S_IDLE) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
        end
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            inh_cnt_q   <= '0;
            n_q         <= 4'd0;
            sh_q        <= '0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            inh_cnt_q   <= inh_cnt_d;
            n_q         <= n_d;
            sh_q        <= sh_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            clk_prev_q  <= clk_prev_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    assign ps2_clk_oe     = clk_oe_q;
    assign ps2_data_oe    = data_oe_q;
    assign tx.tx_ready    = ready_q;
    assign tx.tx_busy     = busy_q;
    assign tx.tx_done     = done_q;
    assign tx.tx_err      = err_q;
    assign tx.tx_err_code = err_code_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomised bench for ps2_host_tx: a behavioural PS/2 device clocks frames and
// the observed line levels and outcomes are compared against a frame model.
module tb_ps2_host_tx;
    localparam int unsigned IC = 16;
    localparam int unsigned TC = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk_oe, ps2_data_oe;
    logic ps2_clk_i, ps2_data_i;

    // Open-drain lines: low if either side pulls
    assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_i = dev_data & ~ps2_data_oe;

    ps2_host_tx_if tx_if();

    ps2_host_tx #(.INHIBIT_CYCLES(IC), .TIMEOUT_CYCLES(TC)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx          (tx_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int fall_cyc = 0;
    logic [1:0] last_code = 2'b00;
    logic pulse_bad = 1'b0;

    // Outcome monitor
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tx_if.tx_done) done_cnt <= done_cnt + 1;
        if (tx_if.tx_err) begin
            err_cnt   <= err_cnt + 1;
            last_code <= tx_if.tx_err_code;
            err_cyc   <= cyc;
        end
        if ((tx_if.tx_done || tx_if.tx_err) && (ps2_clk_oe || ps2_data_oe || !tx_if.tx_ready))
            pulse_bad <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Line levels of the ten host-driven bits: data LSB first, odd parity, stop
    function automatic logic [9:0] exp_frame(input logic [7:0] d);
        logic [9:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = d[i];
            ones += int'(d[i]);
        end
        f[8] = (ones % 2 == 0) ? 1'b1 : 1'b0;
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic start_tx(input logic [7:0] d);
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'($urandom);
    endtask

    // Device side: wait for request-to-send, then clock n_edges falls, reading bits before each rise
    task automatic device_frame(input bit ack, input int n_edges, output logic [9:0] seen, output bit ok);
        int t;
        int hi;
        int lo;
        t = 0;
        seen = '0;
        ok = 1'b1;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1)) begin
            @(negedge clk);
            t++;
            if (t > 4 * int'(IC)) begin
                ok = 1'b0;
                return;
            end
        end
        for (int j = 1; j <= n_edges; j++) begin
            hi = int'($urandom_range(8, 20));
            lo = int'($urandom_range(8, 20));
            repeat (hi) @(negedge clk);
            if (j == 11 && ack) dev_data = 1'b0;
            dev_clk  = 1'b0;
            fall_cyc = cyc;
            repeat (lo) @(negedge clk);
            if (j <= 10) seen[j-1] = ps2_data_i;
            dev_clk = 1'b1;
        end
        repeat (4) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic await_result(input int d0, input int e0);
        int t;
        t = 0;
        while (done_cnt == d0 && err_cnt == e0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("result_in_time", 32'(t < 300), 32'd1);
        repeat (5) @(negedge clk);
    endtask

    task automatic post_checks(input string tag, input logic [7:0] d, input bit ack,
                               input logic [9:0] seen, input bit ok, input int d0, input int e0);
        chk({tag, "_rts"}, 32'(ok), 32'd1);
        chk({tag, "_bits"}, 32'(seen), 32'(exp_frame(d)));
        chk({tag, "_done"}, 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
        chk({tag, "_err"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
        if (!ack) chk({tag, "_code"}, 32'(last_code), 32'd1);
        chk({tag, "_ready"}, 32'(tx_if.tx_ready), 32'd1);
        chk({tag, "_busy"}, 32'(tx_if.tx_busy), 32'd0);
        chk({tag, "_oe"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input bit ack, input bit check_inhibit);
        logic [9:0] seen;
        bit ok;
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(d);
        if (check_inhibit) begin
            for (int m = 1; m <= int'(IC) + 2; m++) begin
                if (m == 1) begin
                    chk("acc_clk_oe", 32'(ps2_clk_oe), 32'd1);
                    chk("acc_ready", 32'(tx_if.tx_ready), 32'd0);
                    chk("acc_busy", 32'(tx_if.tx_busy), 32'd1);
                end
                if (m == int'(IC)) chk("inh_data_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd2);
                if (m == int'(IC) + 1) chk("req_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd3);
                if (m == int'(IC) + 2) chk("req_exit_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd1);
                if (m < int'(IC) + 2) @(negedge clk);
            end
        end
        device_frame(ack, 11, seen, ok);
        await_result(d0, e0);
        post_checks(tag, d, ack, seen, ok, d0, e0);
    endtask

    initial begin
        logic [9:0] seen;
        bit ok;
        int d0;
        int e0;
        int lat;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        chk("rst_ready", 32'(tx_if.tx_ready), 32'd1);
        chk("rst_busy", 32'(tx_if.tx_busy), 32'd0);
        chk("rst_pulses", 32'({tx_if.tx_done, tx_if.tx_err}), 32'd0);
        chk("rst_code", 32'(tx_if.tx_err_code), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        run_frame("ed", 8'hED, 1'b1, 1'b1);
        run_frame("zero", 8'h00, 1'b1, 1'b0);
        run_frame("ff_nack", 8'hFF, 1'b0, 1'b0);

        // Second request while busy must be dropped
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hED);
        fork
            device_frame(1'b1, 11, seen, ok);
            begin
                repeat (5) @(negedge clk);
                tx_if.tx_data  = 8'h55;
                tx_if.tx_valid = 1'b1;
                repeat (30) @(negedge clk);
                tx_if.tx_valid = 1'b0;
            end
        join
        await_result(d0, e0);
        post_checks("busy_drop", 8'hED, 1'b1, seen, ok, d0, e0);
        repeat (20) @(negedge clk);
        chk("busy_no_restart", 32'({ps2_clk_oe, tx_if.tx_ready}), 32'd1);
        chk("code_hold", 32'(tx_if.tx_err_code), 32'd1);

        // Reset in the middle of a frame
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hA5);
        device_frame(1'b1, 5, seen, ok);
`ifdef PS2_HOST_TX_TIMEOUT_EN
        repeat (10) @(negedge clk);
`else
        repeat (150) @(negedge clk);
        chk("no_wd_err", 32'(err_cnt - e0), 32'd0);
        chk("no_wd_busy", 32'(tx_if.tx_busy), 32'd1);
`endif
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        chk("midrst_ready", 32'(tx_if.tx_ready), 32'd1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        run_frame("f4_after_rst", 8'hF4, 1'b1, 1'b0);

`ifdef PS2_HOST_TX_TIMEOUT_EN
        // Device stalls after edge 4
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'h3C);
        device_frame(1'b1, 4, seen, ok);
        await_result(d0, e0);
        lat = err_cyc - fall_cyc;
        chk("to_err", 32'(err_cnt - e0), 32'd1);
        chk("to_done", 32'(done_cnt - d0), 32'd0);
        chk("to_code", 32'(last_code), 32'd2);
        chk("to_latency", 32'(lat >= int'(TC) && lat <= int'(TC) + 6), 32'd1);
        chk("to_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
`endif

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("rnd%0d", i), 8'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
        end

        chk("release_at_pulse", 32'(pulse_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
